fp_round_pipe: RTL and testbench
================================

// Module: fp_round_pipe
// PURPOSE
//  Pipelined IEEE-style rounding stage for the FP multiplier datapath. It takes a normalised
//  pre-round mantissa plus guard/sticky bits and returns the rounded mantissa and exponent.
//  It renormalises on mantissa carry-out and flags inexact and exponent overflow.
//  Rounding mode is selected per transaction at run time. Two register stages, valid/ready on both sides.
// PARAMETERS
//  MANT_W  24  mantissa width incl. hidden bit (MSB of in_mant must be 1 for normalised input)
//  EXP_W   10  biased exponent width, unsigned
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       input transaction valid
//  in_ready     out  1       block accepts input this cycle
//  in_mode      in   3       0 near-even, 1 zero, 2 +inf, 3 -inf, 4 near-up, 5 away-zero, 6/7 = 0
//  in_sign      in   1       sign of the value
//  in_exp       in   EXP_W   pre-round exponent
//  in_mant      in   MANT_W  truncated mantissa
//  in_guard     in   1       first bit below the LSB
//  in_sticky    in   1       OR of all bits below guard
//  out_valid    out  1       output transaction valid
//  out_ready    in   1       downstream accepts output
//  out_sign     out  1       sign, passed through
//  out_exp      out  EXP_W   rounded exponent
//  out_mant     out  MANT_W  rounded mantissa
//  out_inexact  out  1       guard|sticky
//  out_ovf      out  1       out_exp is all ones (inf range)
// BEHAVIOUR
//  Reset (async assert, sync deassert usage): both stage valids=0, all out_* = 0, in-flight data dropped.
//  Handshake: transfer when valid&ready. adv2 = !v2 | out_ready; in_ready = !v1 | adv2 (combinational).
//   out_* held stable while out_valid & !out_ready. Throughput 1/cycle, latency 2 cycles with no stall.
//  Stage 1 (on accept): lsb=in_mant[0], inexact=guard|sticky. inc decision:
//   mode0 near-even: guard & (sticky | lsb)   mode4 near-up: guard
//   mode1 zero: 0   mode2 +inf: inexact & !sign   mode3 -inf: inexact & sign
//   mode5 away-zero: inexact   mode6/7: treated as mode0
//   Register sign, exp, mant, inc, inexact.
//  Stage 2 (when adv2): sum = {1'b0,mant} + inc (MANT_W+1 bits).
//   If sum[MANT_W]=1: out_mant = sum[MANT_W:1], exp_r = exp + 1. Else out_mant = sum[MANT_W-1:0], exp_r = exp.
//   Exponent increment is EXP_W+1 wide. If exp_r >= 2^EXP_W - 1: out_exp = all ones, out_ovf=1,
//    out_mant = {1'b1, zeros}. Otherwise out_ovf=0.
//   out_inexact carried from stage 1. The ovf case does not change out_inexact.
//  Simultaneous: accept and emit in the same cycle is allowed (full pipe, out_ready=1 -> in_ready=1).
//  Stall: out_ready=0 with both stages full -> in_ready=0, nothing overwritten.
//  Non-normalised in_mant (MSB=0) is rounded arithmetically the same way. No check is made.
// TESTING (MANT_W=24, EXP_W=10)
//  T1 mode0, mant=0xFFFFFF g=1 s=0 exp=0x080 -> 2 cycles later mant=0x800000 exp=0x081 inexact=1 ovf=0
//  T2 mode0, mant=0x800000 g=1 s=0 -> mant=0x800000 (tie to even, no inc), inexact=1.
//     Same with mode4 -> 0x800001.
//  T3 mode2 sign=0 g=0 s=0 mant=0x900000 -> mant=0x900000 inexact=0. mode2 sign=1 g=1 -> no inc.
//     mode3 sign=1 s=1 -> 0x900001.
//  T4 mode5, exp=0x3FE mant=0xFFFFFF s=1 -> exp=0x3FF mant=0x800000 ovf=1 inexact=1
//  T5 back-to-back 8 txns, out_ready toggles 1,0,0,1...
//     -> all 8 emerge in order, none lost or duplicated, outputs stable while stalled.
//  T6 rst_n low with 2 txns in flight -> out_valid=0 next edge, all out_* = 0.
//     After release, a new txn has 2-cycle latency.

Source files
------------

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage rounding pipeline (round decision, then increment/renormalise/overflow) with valid/ready on both sides.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with in_mode, in_sign, in_exp, in_mant, in_guard, in_sticky;
//        out_valid/out_ready with out_sign, out_exp, out_mant, out_inexact, out_ovf.
module fp_round_pipe #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_guard,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_inexact,
  output logic              out_ovf
);
  logic              r_v1, r_sign1, r_inc1, r_inx1;
  logic [EXP_W-1:0]  r_exp1;
  logic [MANT_W-1:0] r_mant1;
  logic              r_v2, r_sign2, r_inx2, r_ovf2;
  logic [EXP_W-1:0]  r_exp2;
  logic [MANT_W-1:0] r_mant2;
  logic              w_adv2, w_inx, w_rne, w_inc, w_ovf;
  logic [MANT_W:0]   w_sum;
  logic [EXP_W:0]    w_exp_r;
  logic [MANT_W-1:0] w_mant;
  logic [EXP_W-1:0]  w_exp;
  assign w_adv2   = !r_v2 | out_ready;
  assign in_ready = !r_v1 | w_adv2;
  always_comb begin
    w_inx = in_guard | in_sticky;
    w_rne = in_guard & (in_sticky | in_mant[0]);
    // modes 6 and 7 fall through to round-to-nearest-even
    w_inc = (in_mode == 3'd1) ? 1'b0 :
            (in_mode == 3'd2) ? w_inx & !in_sign :
            (in_mode == 3'd3) ? w_inx & in_sign :
            (in_mode == 3'd4) ? in_guard :
            (in_mode == 3'd5) ? w_inx : w_rne;
  end
  always_comb begin
    w_sum   = {1'b0, r_mant1} + {{MANT_W{1'b0}}, r_inc1};
    // carry-out renormalises by one place and bumps the exponent (one extra bit catches wrap)
    w_exp_r = {1'b0, r_exp1} + {{EXP_W{1'b0}}, w_sum[MANT_W]};
    w_ovf   = w_exp_r >= {1'b0, {EXP_W{1'b1}}};
    w_mant  = w_ovf ? {1'b1, {(MANT_W-1){1'b0}}} :
              w_sum[MANT_W] ? w_sum[MANT_W:1] : w_sum[MANT_W-1:0];
    w_exp   = w_ovf ? {EXP_W{1'b1}} : w_exp_r[EXP_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_sign1 <= 1'b0;
      r_inc1  <= 1'b0;
      r_inx1  <= 1'b0;
      r_exp1  <= '0;
      r_mant1 <= '0;
    end else if (in_ready) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_sign1 <= in_sign;
        r_inc1  <= w_inc;
        r_inx1  <= w_inx;
        r_exp1  <= in_exp;
        r_mant1 <= in_mant;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_sign2 <= 1'b0;
      r_inx2  <= 1'b0;
      r_ovf2  <= 1'b0;
      r_exp2  <= '0;
      r_mant2 <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sign2 <= r_sign1;
        r_inx2  <= r_inx1;
        r_ovf2  <= w_ovf;
        r_exp2  <= w_exp;
        r_mant2 <= w_mant;
      end
    end
  end
  assign out_valid   = r_v2;
  assign out_sign    = r_sign2;
  assign out_exp     = r_exp2;
  assign out_mant    = r_mant2;
  assign out_inexact = r_inx2;
  assign out_ovf     = r_ovf2;
endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: directed vectors with a queue scoreboard and an independent output monitor.
module tb_fp_round_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_mode = '0;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic        in_guard = 1'b0;
  logic        in_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_inexact;
  logic        out_ovf;
  typedef struct {
    logic [23:0] mant;
    logic [9:0]  exp;
    logic        sign, inx, ovf, lat;
    int          acc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  fp_round_pipe #(.MANT_W(24), .EXP_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_guard(in_guard), .in_sticky(in_sticky), .out_valid(out_valid),
    .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_mant(out_mant), .out_inexact(out_inexact), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  // out_ready: 0 = always 1, 1 = pattern 1,0,0 repeating, 2 = always 0
  initial begin
    int k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : (k % 3 == 0);
      k++;
    end
  end
  // monitor: pop on every transfer, and require held outputs while stalled
  initial begin
    logic held = 1'b0;
    logic [23:0] hm;
    logic [9:0] he;
    logic [3:0] hf;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || !out_valid) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_mant", 32'(out_mant), 32'(hm));
          chk("stall_exp", 32'(out_exp), 32'(he));
          chk("stall_flags", 32'({out_sign, out_inexact, out_ovf, 1'b0}), 32'(hf));
        end
        if (out_ready) begin
          held = 1'b0;
          if (q.size() == 0) begin
            chk("unexpected_output", 32'(out_mant), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("mant", 32'(out_mant), 32'(e.mant));
            chk("exp", 32'(out_exp), 32'(e.exp));
            chk("sign", 32'(out_sign), 32'(e.sign));
            chk("inexact", 32'(out_inexact), 32'(e.inx));
            chk("ovf", 32'(out_ovf), 32'(e.ovf));
            if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
          end
        end else begin
          held = 1'b1;
          hm = out_mant;
          he = out_exp;
          hf = {out_sign, out_inexact, out_ovf, 1'b0};
        end
      end
    end
  end
  // presents one transaction, pushes its expectation at acceptance, returns just after the accepting edge
  task automatic send(input logic [2:0] mode, input logic sign, input logic [9:0] ex,
                      input logic [23:0] m, input logic g, input logic s,
                      input logic [23:0] em, input logic [9:0] ee, input logic ei,
                      input logic eo, input logic lat);
    exp_t e;
    bit ok = 0;
    in_valid = 1'b1;
    in_mode = mode;
    in_sign = sign;
    in_exp = ex;
    in_mant = m;
    in_guard = g;
    in_sticky = s;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.mant = em; e.exp = ee; e.sign = sign; e.inx = ei; e.ovf = eo;
        e.lat = lat; e.acc = cyc;
        q.push_back(e);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask
  task automatic chk_reset_outs;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({out_sign, out_exp, out_mant, out_inexact, out_ovf}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    // T1 carry-out renormalise
    send(3'd0, 0, 10'h080, 24'hFFFFFF, 1, 0, 24'h800000, 10'h081, 1, 0, 1);
    idle(4);
    // T2 tie-to-even vs near-up
    send(3'd0, 0, 10'h080, 24'h800000, 1, 0, 24'h800000, 10'h080, 1, 0, 0);
    send(3'd4, 0, 10'h080, 24'h800000, 1, 0, 24'h800001, 10'h080, 1, 0, 0);
    // T3 directed modes
    send(3'd2, 0, 10'h080, 24'h900000, 0, 0, 24'h900000, 10'h080, 0, 0, 0);
    send(3'd2, 1, 10'h080, 24'h900000, 1, 0, 24'h900000, 10'h080, 1, 0, 0);
    send(3'd3, 1, 10'h080, 24'h900000, 0, 1, 24'h900001, 10'h080, 1, 0, 0);
    // T4 overflow via carry
    send(3'd5, 0, 10'h3FE, 24'hFFFFFF, 0, 1, 24'h800000, 10'h3FF, 1, 1, 0);
    // further boundaries
    send(3'd1, 0, 10'h080, 24'h900000, 1, 1, 24'h900000, 10'h080, 1, 0, 0);
    send(3'd6, 0, 10'h080, 24'h800001, 1, 0, 24'h800002, 10'h080, 1, 0, 0);
    send(3'd7, 1, 10'h080, 24'h800001, 1, 0, 24'h800002, 10'h080, 1, 0, 0);
    send(3'd0, 0, 10'h080, 24'h800000, 1, 1, 24'h800001, 10'h080, 1, 0, 0);
    send(3'd2, 0, 10'h080, 24'h900000, 0, 1, 24'h900001, 10'h080, 1, 0, 0);
    send(3'd0, 0, 10'h3FF, 24'hA00000, 0, 0, 24'h800000, 10'h3FF, 0, 1, 0);
    send(3'd4, 0, 10'h080, 24'h7FFFFF, 1, 0, 24'h800000, 10'h080, 1, 0, 0);
    send(3'd5, 1, 10'h3FD, 24'hFFFFFF, 0, 1, 24'h800000, 10'h3FE, 1, 0, 0);
    idle(1);
    drain();
    // T5 back-to-back with out_ready 1,0,0,...
    rdy_mode = 1;
    send(3'd0, 0, 10'h100, 24'h800000, 0, 0, 24'h800000, 10'h100, 0, 0, 0);
    send(3'd0, 0, 10'h101, 24'h800001, 1, 0, 24'h800002, 10'h101, 1, 0, 0);
    send(3'd0, 0, 10'h102, 24'h800002, 0, 1, 24'h800002, 10'h102, 1, 0, 0);
    send(3'd0, 0, 10'h103, 24'h800003, 1, 1, 24'h800004, 10'h103, 1, 0, 0);
    send(3'd0, 0, 10'h104, 24'h800004, 0, 0, 24'h800004, 10'h104, 0, 0, 0);
    send(3'd0, 0, 10'h105, 24'h800005, 1, 0, 24'h800006, 10'h105, 1, 0, 0);
    send(3'd0, 0, 10'h106, 24'h800006, 0, 1, 24'h800006, 10'h106, 1, 0, 0);
    send(3'd0, 0, 10'h107, 24'h800007, 1, 1, 24'h800008, 10'h107, 1, 0, 0);
    idle(1);
    drain();
    // full pipe with out_ready held low must block input
    rdy_mode = 2;
    idle(1);
    send(3'd0, 0, 10'h0A0, 24'hC00000, 0, 0, 24'hC00000, 10'h0A0, 0, 0, 0);
    send(3'd0, 0, 10'h0A1, 24'hC00001, 0, 0, 24'hC00001, 10'h0A1, 0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    rdy_mode = 0;
    idle(1);
    drain();
    // T6 reset with two in flight
    send(3'd0, 0, 10'h055, 24'h811111, 0, 0, 24'h811111, 10'h055, 0, 0, 0);
    send(3'd0, 0, 10'h056, 24'h822222, 0, 0, 24'h822222, 10'h056, 0, 0, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs();
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send(3'd4, 0, 10'h012, 24'h8000FF, 1, 0, 24'h800100, 10'h012, 1, 0, 1);
    idle(1);
    drain();
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
